// File: rtl/ps2_led_sequencer.sv
// PS/2 "Set LEDs" sequencer: sends 0xED then the LED byte, waiting for an ACK after each.
// Define PS2_SEQ_RESEND_EN to retry a byte on 0xFE (up to MAX_RETRY times); otherwise 0xFE aborts.
module ps2_led_sequencer #(
   parameter int ACK_TIMEOUT = 2_500_000,
   parameter int MAX_RETRY   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req,
   input  logic [2:0] leds,
   output logic       busy,
   output logic       done_tick,
   output logic       err_tick,
   output logic [7:0] the_command,
   output logic       send_command,
   input  logic       command_was_sent,
   input  logic       error_communication_timed_out,
   input  logic [7:0] received_data,
   input  logic       received_data_en,
   output logic [7:0] scan_data,
   output logic       scan_valid
);

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] RX_ACK       = 8'hFA;
   localparam logic [7:0] RX_RESEND    = 8'hFE;

   localparam int unsigned TMR_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

   if (ACK_TIMEOUT < 2 || MAX_RETRY < 0) begin : g_bad_cfg
      $error("ps2_led_sequencer: ACK_TIMEOUT must be >= 2 and MAX_RETRY >= 0");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND_CMD,
      S_WAIT_ACK1,
      S_SEND_ARG,
      S_WAIT_ACK2,
      S_DONE,
      S_ERR
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       arg_q, arg_d;
   logic [TMR_W-1:0] timer_q, timer_d;

`ifdef PS2_SEQ_RESEND_EN
   localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
   logic [RTY_W-1:0] retry_q, retry_d;
`endif

   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic       send_q, send_d;
   logic [7:0] cmd_q, cmd_d;
   logic       scan_valid_q, scan_valid_d;
   logic [7:0] scan_data_q, scan_data_d;

   logic rx_ack, rx_resend, in_wait;

   always_comb begin
      rx_ack    = received_data_en && (received_data == RX_ACK);
      rx_resend = received_data_en && (received_data == RX_RESEND);
      in_wait   = (state_q == S_WAIT_ACK1) || (state_q == S_WAIT_ACK2);
   end

   always_comb begin
      state_d = state_q;
      arg_d   = arg_q;
      timer_d = timer_q;
`ifdef PS2_SEQ_RESEND_EN
      retry_d = retry_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               arg_d   = {5'b0, leds};
`ifdef PS2_SEQ_RESEND_EN
               retry_d = '0;
`endif
               state_d = S_SEND_CMD;
            end
         end
         S_SEND_CMD, S_SEND_ARG: begin
            // A transmit failure outranks a simultaneous completion.
            if (error_communication_timed_out) begin
               state_d = S_ERR;
            end else if (command_was_sent) begin
               timer_d = '0;
               state_d = (state_q == S_SEND_CMD) ? S_WAIT_ACK1 : S_WAIT_ACK2;
            end
         end
         S_WAIT_ACK1, S_WAIT_ACK2: begin
            if (timer_q != '1) timer_d = timer_q + 1'b1;
            if (rx_ack) begin
`ifdef PS2_SEQ_RESEND_EN
               retry_d = '0;
`endif
               state_d = (state_q == S_WAIT_ACK1) ? S_SEND_ARG : S_DONE;
            end else if (rx_resend) begin
`ifdef PS2_SEQ_RESEND_EN
               if (retry_q < RTY_MAX) begin
                  retry_d = retry_q + 1'b1;
                  timer_d = '0;
                  state_d = (state_q == S_WAIT_ACK1) ? S_SEND_CMD : S_SEND_ARG;
               end else begin
                  state_d = S_ERR;
               end
`else
               state_d = S_ERR;
`endif
            end else if (timer_q == TMR_LAST) begin
               state_d = S_ERR;
            end
         end
         S_DONE, S_ERR: state_d = S_IDLE;
         default:       state_d = S_IDLE;
      endcase
   end

   // Outputs are registered copies of the current state, so they trail the state by one edge.
   always_comb begin
      busy_d = (state_q != S_IDLE);
      done_d = (state_q == S_DONE);
      err_d  = (state_q == S_ERR);
      send_d = (state_q == S_SEND_CMD) || (state_q == S_SEND_ARG);
      cmd_d  = cmd_q;
      if (state_q == S_SEND_CMD)      cmd_d = CMD_SET_LEDS;
      else if (state_q == S_SEND_ARG) cmd_d = arg_q;
      scan_valid_d = received_data_en && !(in_wait && (rx_ack || rx_resend));
      scan_data_d  = scan_valid_d ? received_data : scan_data_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         arg_q        <= '0;
         timer_q      <= '0;
`ifdef PS2_SEQ_RESEND_EN
         retry_q      <= '0;
`endif
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         send_q       <= 1'b0;
         cmd_q        <= '0;
         scan_valid_q <= 1'b0;
         scan_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         arg_q        <= arg_d;
         timer_q      <= timer_d;
`ifdef PS2_SEQ_RESEND_EN
         retry_q      <= retry_d;
`endif
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         send_q       <= send_d;
         cmd_q        <= cmd_d;
         scan_valid_q <= scan_valid_d;
         scan_data_q  <= scan_data_d;
      end
   end

   assign busy         = busy_q;
   assign done_tick    = done_q;
   assign err_tick     = err_q;
   assign send_command = send_q;
   assign the_command  = cmd_q;
   assign scan_valid   = scan_valid_q;
   assign scan_data    = scan_data_q;

endmodule

// File: tb/tb_ps2_led_sequencer.sv
// Self-checking bench for ps2_led_sequencer: directed and random LED transactions against a
// transaction-level model of the expected byte sequence, outcome and forwarded bytes.
module tb_ps2_led_sequencer;

   localparam int T  = 100;
   localparam int MR = 3;
`ifdef PS2_SEQ_RESEND_EN
   localparam bit RESEND = 1'b1;
`else
   localparam bit RESEND = 1'b0;
`endif
   localparam int R_TIMEOUT = -1;
   localparam int R_TXERR   = -2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       req = 1'b0;
   logic [2:0] leds = '0;
   logic       cws = 1'b0;
   logic       cerr = 1'b0;
   logic [7:0] rdata = '0;
   logic       ren = 1'b0;
   logic       busy, done_tick, err_tick, send_command, scan_valid;
   logic [7:0] the_command, scan_data;

   always #5 clk = ~clk;

   ps2_led_sequencer #(.ACK_TIMEOUT(T), .MAX_RETRY(MR)) dut (
      .clk                           (clk),
      .reset                         (reset),
      .req                           (req),
      .leds                          (leds),
      .busy                          (busy),
      .done_tick                     (done_tick),
      .err_tick                      (err_tick),
      .the_command                   (the_command),
      .send_command                  (send_command),
      .command_was_sent              (cws),
      .error_communication_timed_out (cerr),
      .received_data                 (rdata),
      .received_data_en              (ren),
      .scan_data                     (scan_data),
      .scan_valid                    (scan_valid)
   );

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Observation side: bytes offered on each send_command rise, forwarded bytes, ticks.
   logic [7:0]  sent_q[$];
   logic [7:0]  fwd_q[$];
   int          n_done = 0;
   int          n_err = 0;
   logic        sc_prev = 1'b0;

   always @(negedge clk) begin
      if (send_command && !sc_prev) sent_q.push_back(the_command);
      sc_prev = send_command;
      if (scan_valid) fwd_q.push_back(scan_data);
      if (done_tick) n_done++;
      if (err_tick) n_err++;
   end

   // Model state
   int         script[$];
   logic [7:0] exp_sent[$];
   logic [7:0] exp_fwd[$];
   bit         exp_ok;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_rx(input logic [7:0] b);
      rdata = b;
      ren   = 1'b1;
      tick();
      ren   = 1'b0;
      rdata = 8'($urandom);
   endtask

   // Walk the device's responses: which bytes get transmitted, and does it end in success.
   task automatic predict(input logic [2:0] l);
      logic [7:0] bytes_[2];
      int idx;
      int tries;
      bytes_[0] = 8'hED;
      bytes_[1] = {5'b0, l};
      idx   = 0;
      tries = 0;
      exp_sent.delete();
      exp_ok = 1'b0;
      foreach (script[i]) begin
         exp_sent.push_back(bytes_[idx]);
         if (script[i] == 8'hFA) begin
            idx++;
            tries = 0;
            if (idx == 2) begin
               exp_ok = 1'b1;
               return;
            end
         end else if (script[i] == 8'hFE && RESEND && tries < MR) begin
            tries++;
         end else begin
            return;
         end
      end
   endtask

   task automatic run_txn(input string tag, input logic [2:0] l, input bit passthru, input bit spam_req);
      bit          ok;
      int unsigned cws_cyc;
      logic [7:0]  b;
      predict(l);
      sent_q.delete();
      fwd_q.delete();
      exp_fwd.delete();
      n_done = 0;
      n_err  = 0;
      req  = 1'b1;
      leds = l;
      tick();
      req  = 1'b0;
      leds = 3'($urandom);
      for (int i = 0; i < exp_sent.size(); i++) begin
         ok = 1'b0;
         for (int w = 0; w < 20 && !ok; w++) begin
            tick();
            ok = (sent_q.size() > i);
         end
         check({tag, " send_seen"}, 32'(ok), 1);
         if (!ok) break;
         repeat ($urandom_range(0, 2)) tick();
         if (script[i] == R_TXERR) begin
            cws  = 1'b1;
            cerr = 1'b1;
            tick();
            cws  = 1'b0;
            cerr = 1'b0;
            tick();
            check({tag, " txerr_send_drop"}, 32'(send_command), 0);
            check({tag, " txerr_err_tick"}, 32'(err_tick), 1);
            break;
         end
         cws = 1'b1;
         tick();
         cws = 1'b0;
         cws_cyc = cyc;
         if (spam_req) begin
            req = 1'b1;
            tick();
            req = 1'b0;
         end
         if (passthru) begin
            do b = 8'($urandom); while (b == 8'hFA || b == 8'hFE);
            repeat ($urandom_range(0, 2)) tick();
            send_rx(b);
            exp_fwd.push_back(b);
         end
         if (script[i] == R_TIMEOUT) begin
            ok = 1'b0;
            for (int w = 0; w < T + 20 && !ok; w++) begin
               tick();
               ok = err_tick;
            end
            check({tag, " timeout_seen"}, 32'(ok), 1);
            if (ok) check({tag, " timeout_latency"}, 32'((cyc - cws_cyc) inside {[T-1:T+1]}), 1);
            break;
         end
         repeat ($urandom_range(0, 3)) tick();
         send_rx(8'(script[i]));
      end
      ok = 1'b0;
      for (int w = 0; w < 20 && !ok; w++) begin
         tick();
         ok = !busy && (n_done + n_err) > 0;
      end
      repeat (3) tick();
      check({tag, " done_count"}, 32'(n_done), 32'(exp_ok));
      check({tag, " err_count"}, 32'(n_err), 32'(!exp_ok));
      check({tag, " busy_idle"}, 32'(busy), 0);
      check({tag, " sent_count"}, 32'(sent_q.size()), 32'(exp_sent.size()));
      for (int k = 0; k < exp_sent.size() && k < sent_q.size(); k++)
         check({tag, " sent_byte"}, 32'(sent_q[k]), 32'(exp_sent[k]));
      check({tag, " fwd_count"}, 32'(fwd_q.size()), 32'(exp_fwd.size()));
      for (int k = 0; k < exp_fwd.size() && k < fwd_q.size(); k++)
         check({tag, " fwd_byte"}, 32'(fwd_q[k]), 32'(exp_fwd[k]));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " busy"}, 32'(busy), 0);
      check({tag, " done_tick"}, 32'(done_tick), 0);
      check({tag, " err_tick"}, 32'(err_tick), 0);
      check({tag, " send_command"}, 32'(send_command), 0);
      check({tag, " the_command"}, 32'(the_command), 0);
      check({tag, " scan_valid"}, 32'(scan_valid), 0);
      check({tag, " scan_data"}, 32'(scan_data), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int r;
      reset = 1'b0;
      repeat (3) tick();
      check_reset_values("por");
      reset = 1'b1;
      tick();

      script = '{8'hFA, 8'hFA};
      run_txn("happy", 3'b101, 1'b0, 1'b0);
      check("happy cmd0", 32'(sent_q.size() > 0 ? sent_q[0] : 8'h00), 32'h00ED);
      check("happy cmd1", 32'(sent_q.size() > 1 ? sent_q[1] : 8'h00), 32'h0005);

      script = '{8'hFA, 8'hFA};
      run_txn("passthru", 3'b010, 1'b1, 1'b0);

      fwd_q.delete();
      send_rx(8'hFA);
      send_rx(8'hFE);
      repeat (2) tick();
      check("idle_fwd count", 32'(fwd_q.size()), 2);
      check("idle_fwd fa", 32'(fwd_q.size() > 0 ? fwd_q[0] : 8'h00), 32'h00FA);
      check("idle_fwd fe", 32'(fwd_q.size() > 1 ? fwd_q[1] : 8'h00), 32'h00FE);

      script = '{R_TIMEOUT};
      run_txn("timeout", 3'b111, 1'b0, 1'b0);
      script = '{8'hFA, 8'hFA};
      run_txn("after_timeout", 3'b001, 1'b0, 1'b0);

      script = '{8'hFE, 8'hFE, 8'hFA, 8'hFA};
      run_txn("resend2", 3'b100, 1'b0, 1'b0);
      script = '{8'hFE, 8'hFE, 8'hFE, 8'hFE};
      run_txn("resend4", 3'b011, 1'b0, 1'b0);

      script = '{8'hFA, R_TXERR};
      run_txn("txerr", 3'b110, 1'b0, 1'b0);

      script = '{8'hFA, 8'hFA};
      run_txn("spam_req", 3'b001, 1'b0, 1'b1);

      // Reset while waiting for the second ACK.
      sent_q.delete();
      n_done = 0;
      n_err  = 0;
      req  = 1'b1;
      leds = 3'b011;
      tick();
      req  = 1'b0;
      ok = 1'b0;
      for (int w = 0; w < 20 && !ok; w++) begin tick(); ok = (sent_q.size() > 0); end
      cws = 1'b1; tick(); cws = 1'b0;
      send_rx(8'hFA);
      ok = 1'b0;
      for (int w = 0; w < 20 && !ok; w++) begin tick(); ok = (sent_q.size() > 1); end
      check("rst_mid second_send", 32'(ok), 1);
      cws = 1'b1; tick(); cws = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      check_reset_values("rst_mid");
      reset = 1'b1;
      repeat (5) tick();
      check("rst_mid no_done", 32'(n_done), 0);
      check("rst_mid no_err", 32'(n_err), 0);
      check("rst_mid idle", 32'(busy), 0);

      for (int t = 0; t < 10; t++) begin
         script.delete();
         for (int k = 0; k < 12; k++) begin
            r = $urandom_range(0, 19);
            if (r < 14)      script.push_back(8'hFA);
            else if (r < 18) script.push_back(8'hFE);
            else if (r < 19) script.push_back(R_TIMEOUT);
            else             script.push_back(R_TXERR);
         end
         run_txn($sformatf("rand%0d", t), 3'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
